store_align_stage: RTL and testbench
====================================

Name: store_align_stage

Overview:
Store-path stage of the load/store unit that turns a CPU store request into a word-aligned memory write.
- Masks the store data to the access size, then shifts data and byte mask into lane position with the shiftLeft barrel shifter.
- Rejects misaligned accesses.
- Buffers accepted writes in a small FIFO with valid/ready handshakes on both sides, between the EX-stage store issue and the data-memory write port.

Parameters:
DEPTH, 2, FIFO entries (power of two, >=2)
CNT_W, 8, width of the saturating misalign counter

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_req_valid  in  1  store request valid
o_req_ready  out  1  stage can accept a request
i_req_addr  in  32  byte address
i_req_data  in  32  store data, right-justified
i_req_size  in  2  00 byte (SB), 01 half (SH), 10 word (SW), 11 illegal
o_mem_valid  out  1  write request valid toward memory
i_mem_ready  in  1  memory accepts write
o_mem_addr  out  32  word address, {i_req_addr[31:2],2'b00}
o_mem_wdata  out  32  lane-aligned write data
o_mem_bmask  out  4  byte-lane write enables
o_misalign  out  1  one-cycle pulse: previous accepted request was rejected
o_misalign_cnt  out  CNT_W  saturating count of rejected requests

Behaviour:
- Reset (async, i_reset=1): FIFO emptied, pointers/count 0, o_mem_valid=0, o_mem_addr/wdata/bmask=0, o_misalign=0, o_misalign_cnt=0, o_req_ready=1 after release.
- Accept: i_req_valid & o_req_ready at a rising edge.
- o_req_ready = !full. There is no same-cycle pass-through when full, even if i_mem_ready=1.
- Alignment computation on the accept cycle, combinational:
  - off = i_req_addr[1:0]; shamt = {off,3'b000}.
  - Size mask: byte 0x000000FF, half 0x0000FFFF, word 0xFFFFFFFF.
  - wdata = shiftLeft(i_req_data & size mask, shamt).
  - Base bmask: byte 0001, half 0011, word 1111; bmask = base << off.
- Misaligned when: half with off[0]=1, or word with off!=0, or size=11.
  - Misaligned requests are accepted (handshake completes) but not enqueued.
  - o_misalign=1 for exactly the cycle after the accept edge.
  - o_misalign_cnt increments and holds at 2^CNT_W-1.
- Legal requests are pushed into the FIFO as {addr word, wdata, bmask}.
- Output side: o_mem_* reflect the FIFO head. o_mem_valid = !empty. A pop occurs on o_mem_valid & i_mem_ready.
- Latency: a request accepted at edge N has o_mem_valid=1 in the cycle after edge N when the FIFO was empty, i.e. 1 cycle.
- Order is preserved.
- Stability: while o_mem_valid & !i_mem_ready, o_mem_addr/wdata/bmask hold unchanged.
- Simultaneous push and pop when not full: both happen and the count is unchanged.
- Push while empty plus pop is impossible, since there is no bypass.
- Pointers wrap modulo DEPTH; full/empty derive from an occupancy counter of width clog2(DEPTH)+1.
- Reset mid-operation: all pending writes are discarded and no o_mem_valid appears after release until a new accept.
- A misaligned accept while full cannot occur, because ready is low.

Decomposition:
- Package store_align_pkg:
  - enum size_e {SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_ILL=2'b11}
  - size-mask constants
  - base byte-mask constants
  - struct mem_wr_t {addr, wdata, bmask}
- Sub-modules:
  - Data shift: instantiate the existing shiftLeft (i_agr, i_shift, o_data).
  - Byte-mask shift: a second shiftLeft on the zero-extended mask, with i_shift={3'b0,off}; use bits [3:0].
  - FIFO storage and pointers stay inline; a separate FIFO module is not warranted.

Test Plan:
- SB addr=0x1003 data=0x12345678, i_mem_ready=1 -> next cycle o_mem_valid=1, addr=0x1000, wdata=0x78000000, bmask=1000, o_misalign=0.
- SH addr=0x2002 data=0xAAAABEEF -> wdata=0xBEEF0000, bmask=1100. SW addr=0x2000 data=0xCAFEF00D -> wdata=0xCAFEF00D, bmask=1111.
- SH addr=0x3001, then SW addr=0x3002, then size=11 -> each accepted, o_misalign pulses 1 cycle each, no o_mem_valid, cnt=3. Force 300 rejects -> cnt stays 255.
- i_mem_ready=0, push 2 legal stores -> o_req_ready=0 after second. Third request waits with head stable. Raise i_mem_ready -> writes drain in order, ready returns the cycle after the first pop.
- Continuous requests with i_mem_ready=1 -> one write per cycle, with push and pop each cycle once steady, and no drops.
- Assert i_reset with 2 entries pending, mid-cycle (asynchronous) -> o_mem_valid=0 immediately; after release no stale writes, o_misalign_cnt=0.

Source files
------------

// File: rtl/store_align_pkg.sv
// Shared types and constants for the store alignment stage: access sizes,
// per-size data and byte-lane masks, and the queued memory-write record.
package store_align_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    localparam logic [31:0] MASK_BYTE = 32'h0000_00FF;
    localparam logic [31:0] MASK_HALF = 32'h0000_FFFF;
    localparam logic [31:0] MASK_WORD = 32'hFFFF_FFFF;

    localparam logic [3:0] BMASK_BYTE = 4'b0001;
    localparam logic [3:0] BMASK_HALF = 4'b0011;
    localparam logic [3:0] BMASK_WORD = 4'b1111;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bmask;
    } mem_wr_t;

endpackage

// File: rtl/store_align_stage_shift.sv
// 32-bit logarithmic left barrel shifter (shiftLeft), shared by the data and
// byte-mask lane alignment paths.
module shiftLeft (
    input  logic [31:0] i_agr,
    input  logic [4:0]  i_shift,
    output logic [31:0] o_data
);

    logic [31:0] stage_val;

    // Five power-of-two stages; each stage conditionally shifts by 2**s.
    always_comb begin
        stage_val = i_agr;
        for (int s = 0; s < 5; s++) begin
            if (i_shift[s]) begin
                stage_val = stage_val << (1 << s);
            end
        end
        o_data = stage_val;
    end

endmodule

// File: rtl/store_align_stage.sv
// Store-path stage: masks and lane-aligns store data and byte enables, drops
// misaligned requests (counting them), and queues legal writes in a small FIFO.
module store_align_stage
    import store_align_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [31:0]      i_req_addr,
    input  logic [31:0]      i_req_data,
    input  logic [1:0]       i_req_size,
    output logic             o_mem_valid,
    input  logic             i_mem_ready,
    output logic [31:0]      o_mem_addr,
    output logic [31:0]      o_mem_wdata,
    output logic [3:0]       o_mem_bmask,
    output logic             o_misalign,
    output logic [CNT_W-1:0] o_misalign_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    size_e       size;
    logic [1:0]  off;
    logic [31:0] size_mask;
    logic [3:0]  base_bmask;
    logic        misaligned;
    logic [31:0] wdata_aligned;
    logic [31:0] bmask_wide;
    mem_wr_t     push_entry;
    mem_wr_t     head;

    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]   count_reg, count_next;
    logic             misalign_reg;
    logic [CNT_W-1:0] misalign_cnt_reg;
    logic             full, empty, accept, push, pop;

    mem_wr_t fifo_mem [DEPTH];

    assign size = size_e'(i_req_size);
    assign off  = i_req_addr[1:0];

    always_comb begin
        size_mask  = '0;
        base_bmask = '0;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                size_mask  = MASK_BYTE;
                base_bmask = BMASK_BYTE;
            end
            SZ_HALF: begin
                size_mask  = MASK_HALF;
                base_bmask = BMASK_HALF;
                misaligned = off[0];
            end
            SZ_WORD: begin
                size_mask  = MASK_WORD;
                base_bmask = BMASK_WORD;
                misaligned = (off != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
    end

    shiftLeft u_data_shift (
        .i_agr   (i_req_data & size_mask),
        .i_shift ({off, 3'b000}),
        .o_data  (wdata_aligned)
    );

    shiftLeft u_mask_shift (
        .i_agr   ({28'd0, base_bmask}),
        .i_shift ({3'b000, off}),
        .o_data  (bmask_wide)
    );

    logic unused_bmask_hi;
    assign unused_bmask_hi = ^bmask_wide[31:4];

    assign push_entry.addr  = {i_req_addr[31:2], 2'b00};
    assign push_entry.wdata = wdata_aligned;
    assign push_entry.bmask = bmask_wide[3:0];

    assign full        = (count_reg == FULL_CNT);
    assign empty       = (count_reg == '0);
    assign o_req_ready = !full;
    assign accept      = i_req_valid && o_req_ready;
    assign push        = accept && !misaligned;
    assign pop         = o_mem_valid && i_mem_ready;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Storage carries no reset; the head is gated to zero while empty instead.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= push_entry;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            misalign_reg     <= 1'b0;
            misalign_cnt_reg <= '0;
        end else begin
            count_reg    <= count_next;
            misalign_reg <= accept && misaligned;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (accept && misaligned && (misalign_cnt_reg != '1)) begin
                misalign_cnt_reg <= misalign_cnt_reg + 1'b1;
            end
        end
    end

    assign head           = fifo_mem[rd_ptr_reg];
    assign o_mem_valid    = !empty;
    assign o_mem_addr     = o_mem_valid ? head.addr  : '0;
    assign o_mem_wdata    = o_mem_valid ? head.wdata : '0;
    assign o_mem_bmask    = o_mem_valid ? head.bmask : '0;
    assign o_misalign     = misalign_reg;
    assign o_misalign_cnt = misalign_cnt_reg;

endmodule

// File: tb/tb_store_align_stage.sv
// Directed bench for store_align_stage: a vector table for single-store
// alignment/rejection plus sequences for saturation, backpressure, streaming and reset.
module tb_store_align_stage;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic [31:0] i_req_addr = '0;
    logic [31:0] i_req_data = '0;
    logic [1:0]  i_req_size = '0;
    logic        o_mem_valid;
    logic        i_mem_ready = 1'b0;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        o_misalign;
    logic [7:0]  o_misalign_cnt;

    int total = 0;
    int passed = 0;

    store_align_stage #(.DEPTH(2), .CNT_W(8)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_addr     (i_req_addr),
        .i_req_data     (i_req_data),
        .i_req_size     (i_req_size),
        .o_mem_valid    (o_mem_valid),
        .i_mem_ready    (i_mem_ready),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wdata    (o_mem_wdata),
        .o_mem_bmask    (o_mem_bmask),
        .o_misalign     (o_misalign),
        .o_misalign_cnt (o_misalign_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic        exp_valid;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_bmask;
        logic        exp_mis;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        i_req_valid = 1'b1;
        i_req_addr  = a;
        i_req_data  = d;
        i_req_size  = s;
    endtask

    initial begin
        vecs[0] = '{32'h0000_1003, 32'h1234_5678, 2'b00, 1'b1, 32'h0000_1000, 32'h7800_0000, 4'b1000, 1'b0};
        vecs[1] = '{32'h0000_2002, 32'hAAAA_BEEF, 2'b01, 1'b1, 32'h0000_2000, 32'hBEEF_0000, 4'b1100, 1'b0};
        vecs[2] = '{32'h0000_2000, 32'hCAFE_F00D, 2'b10, 1'b1, 32'h0000_2000, 32'hCAFE_F00D, 4'b1111, 1'b0};
        vecs[3] = '{32'h0000_4001, 32'hFFFF_FFA5, 2'b00, 1'b1, 32'h0000_4000, 32'h0000_A500, 4'b0010, 1'b0};
        vecs[4] = '{32'h0000_4000, 32'h1234_ABCD, 2'b01, 1'b1, 32'h0000_4000, 32'h0000_ABCD, 4'b0011, 1'b0};
        vecs[5] = '{32'h0000_3001, 32'h1111_1111, 2'b01, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1};
        vecs[6] = '{32'h0000_3002, 32'h2222_2222, 2'b10, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1};
        vecs[7] = '{32'h0000_3000, 32'h3333_3333, 2'b11, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1};

        // Reset state, sampled during and after reset.
        #12;
        check("rst_valid", 32'(o_mem_valid), 32'd0);
        check("rst_addr", o_mem_addr, 32'd0);
        check("rst_wdata", o_mem_wdata, 32'd0);
        check("rst_bmask", 32'(o_mem_bmask), 32'd0);
        #10 i_reset = 1'b0;
        tick();
        check("rst_ready", 32'(o_req_ready), 32'd1);
        check("rst_mis", 32'(o_misalign), 32'd0);
        check("rst_cnt", 32'(o_misalign_cnt), 32'd0);

        // Table: one request per vector, memory always ready.
        i_mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].addr, vecs[i].data, vecs[i].size);
            tick();
            i_req_valid = 1'b0;
            $display("vec %0d addr=%08h size=%0d -> valid=%0d addr=%08h wdata=%08h bmask=%04b mis=%0d",
                     i, vecs[i].addr, vecs[i].size, o_mem_valid, o_mem_addr, o_mem_wdata, o_mem_bmask, o_misalign);
            check($sformatf("v%0d_valid", i), 32'(o_mem_valid), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_mis", i), 32'(o_misalign), 32'(vecs[i].exp_mis));
            check($sformatf("v%0d_ready", i), 32'(o_req_ready), 32'd1);
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d_addr", i), o_mem_addr, vecs[i].exp_addr);
                check($sformatf("v%0d_wdata", i), o_mem_wdata, vecs[i].exp_wdata);
                check($sformatf("v%0d_bmask", i), 32'(o_mem_bmask), 32'(vecs[i].exp_bmask));
            end
        end
        tick();
        check("mis_pulse_end", 32'(o_misalign), 32'd0);
        check("mis_cnt3", 32'(o_misalign_cnt), 32'd3);
        check("mis_no_write", 32'(o_mem_valid), 32'd0);

        // 300 back-to-back illegal-size requests saturate the counter.
        drive(32'h0, 32'h0, 2'b11);
        repeat (300) @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
        $display("saturate: cnt=%0d mis=%0d", o_misalign_cnt, o_misalign);
        check("sat_mis", 32'(o_misalign), 32'd1);
        check("sat_cnt", 32'(o_misalign_cnt), 32'd255);
        tick();
        check("sat_hold", 32'(o_misalign_cnt), 32'd255);
        check("sat_mis_end", 32'(o_misalign), 32'd0);

        // Backpressure: fill, stall a third request, then drain in order.
        i_mem_ready = 1'b0;
        drive(32'h0000_5000, 32'h1111_1111, 2'b10);
        tick();
        check("bp_ready1", 32'(o_req_ready), 32'd1);
        check("bp_head1", o_mem_addr, 32'h0000_5000);
        drive(32'h0000_5004, 32'h2222_2222, 2'b10);
        tick();
        check("bp_full_ready", 32'(o_req_ready), 32'd0);
        drive(32'h0000_5008, 32'h3333_3333, 2'b10);
        for (int k = 0; k < 3; k++) begin
            tick();
            $display("stall %0d: ready=%0d head=%08h/%08h", k, o_req_ready, o_mem_addr, o_mem_wdata);
            check($sformatf("bp_stall%0d_ready", k), 32'(o_req_ready), 32'd0);
            check($sformatf("bp_stall%0d_addr", k), o_mem_addr, 32'h0000_5000);
            check($sformatf("bp_stall%0d_wdata", k), o_mem_wdata, 32'h1111_1111);
            check($sformatf("bp_stall%0d_bmask", k), 32'(o_mem_bmask), 32'hF);
        end
        i_mem_ready = 1'b1;
        tick();
        check("bp_pop1_head", o_mem_wdata, 32'h2222_2222);
        check("bp_pop1_ready", 32'(o_req_ready), 32'd1);
        tick();
        i_req_valid = 1'b0;
        check("bp_pop2_head", o_mem_wdata, 32'h3333_3333);
        check("bp_pop2_addr", o_mem_addr, 32'h0000_5008);
        tick();
        check("bp_drained", 32'(o_mem_valid), 32'd0);

        // Streaming: one write per cycle with push and pop each edge.
        for (int k = 0; k < 6; k++) begin
            drive(32'h0000_6000 + 32'(4 * k), 32'h0101_0101 * 32'(k + 1), 2'b10);
            tick();
            $display("stream %0d: valid=%0d addr=%08h wdata=%08h", k, o_mem_valid, o_mem_addr, o_mem_wdata);
            check($sformatf("st%0d_valid", k), 32'(o_mem_valid), 32'd1);
            check($sformatf("st%0d_addr", k), o_mem_addr, 32'h0000_6000 + 32'(4 * k));
            check($sformatf("st%0d_wdata", k), o_mem_wdata, 32'h0101_0101 * 32'(k + 1));
            check($sformatf("st%0d_ready", k), 32'(o_req_ready), 32'd1);
        end
        i_req_valid = 1'b0;
        tick();
        check("st_drained", 32'(o_mem_valid), 32'd0);

        // Asynchronous reset mid-cycle with two writes pending.
        i_mem_ready = 1'b0;
        drive(32'h0000_7000, 32'hDEAD_0001, 2'b10);
        tick();
        drive(32'h0000_7004, 32'hDEAD_0002, 2'b10);
        tick();
        i_req_valid = 1'b0;
        check("ar_pending", 32'(o_req_ready), 32'd0);
        #3 i_reset = 1'b1;
        #1;
        $display("async reset: valid=%0d cnt=%0d ready=%0d", o_mem_valid, o_misalign_cnt, o_req_ready);
        check("ar_valid", 32'(o_mem_valid), 32'd0);
        check("ar_cnt", 32'(o_misalign_cnt), 32'd0);
        check("ar_ready", 32'(o_req_ready), 32'd1);
        @(posedge i_clk);
        #2 i_reset = 1'b0;
        i_mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("ar_post%0d_valid", k), 32'(o_mem_valid), 32'd0);
        end
        check("ar_post_cnt", 32'(o_misalign_cnt), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
